// File: rtl/jk_reg_bank.sv
// jk_reg_bank: a WIDTH-bit bank of JK flip-flops on one clock. The bank can run as
// independent JK cells, as an up or down counter built from a JK toggle chain, or as
// a left shifter. tc is combinational. q, qnot and wrap are registered.
module jk_reg_bank #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qnot;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic             w_tc;

    // Characteristic equation of one JK cell: Q+ = J&~Q | ~K&Q.
    function automatic logic jk_next(input logic j_b, input logic k_b, input logic q_b);
        return (j_b & ~q_b) | (~k_b & q_b);
    endfunction

    // Toggle enables for the counter chain. Each one is computed from a mask of the
    // lower bits. This avoids a rippling self-referencing vector. Bit 0 always toggles.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
        localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << gi) - WIDTH'(1);
        assign w_up_t[gi] = &(r_q | ~LOW_MASK);
        assign w_dn_t[gi] = ~|(r_q & LOW_MASK);
    end

    // Terminal count: up mode at all-ones, or down mode at zero.
    always_comb begin
        w_tc = 1'b0;
        if (mode == MODE_UP) begin
            w_tc = &r_q;
        end else if (mode == MODE_DOWN) begin
            w_tc = (r_q == {WIDTH{1'b0}});
        end else begin
            w_tc = 1'b0;
        end
    end

    // Next-state selection for the bank. Counting drives J=K from the toggle chain.
    always_comb begin
        w_q_next = r_q;
        if (!en) begin
            w_q_next = r_q;
        end else begin
            case (mode)
                MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        w_q_next[i] = jk_next(j[i], k[i], r_q[i]);
                    end
                end
                MODE_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        w_q_next[i] = jk_next(w_up_t[i], w_up_t[i], r_q[i]);
                    end
                end
                MODE_DOWN: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        w_q_next[i] = jk_next(w_dn_t[i], w_dn_t[i], r_q[i]);
                    end
                end
                MODE_SHIFT: begin
                    w_q_next = {r_q[WIDTH-2:0], ser_in};
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    // State register. Reset has priority over everything. qnot is stored as the
    // complement of the same next value, so q and qnot always agree.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            r_q    <= RESET_VAL;
            r_qnot <= ~RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_qnot <= ~w_q_next;
            r_wrap <= en & w_tc;
        end
    end

    assign q    = r_q;
    assign qnot = r_qnot;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Testbench for jk_reg_bank. Two instances share one set of inputs: RESET_VAL=0 and
// RESET_VAL=5. The driver computes expected results from an arithmetic reference model
// and queues them. The monitor compares them after each rising edge.
module tb_jk_reg_bank;

    logic       clk;
    logic       sync_reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       ser_in;
    logic [3:0] q0, qnot0, q5, qnot5;
    logic       tc0, wrap0, tc5, wrap5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] q0;
        logic       tc0;
        logic       wrap0;
        logic [3:0] q5;
        logic       tc5;
        logic       wrap5;
    } exp_t;

    exp_t sb_q[$];

    // Reference state, one per instance.
    logic [3:0] m_q0, m_q5;
    bit         m_known;

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'd0)) dut0 (
        .clk(clk), .sync_reset_n(sync_reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .ser_in(ser_in), .q(q0), .qnot(qnot0), .tc(tc0), .wrap(wrap0)
    );

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'd5)) dut5 (
        .clk(clk), .sync_reset_n(sync_reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .ser_in(ser_in), .q(q5), .qnot(qnot5), .tc(tc5), .wrap(wrap5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic rn,
                                              input logic e, input logic [1:0] md,
                                              input logic [3:0] jj, input logic [3:0] kk,
                                              input logic s, input logic [3:0] rv);
        logic [3:0] r;
        if (!rn) return rv;
        if (!e) return cur;
        case (md)
            2'd0: begin
                r = cur;
                for (int i = 0; i < 4; i++) begin
                    case ({jj[i], kk[i]})
                        2'b01:   r[i] = 1'b0;
                        2'b10:   r[i] = 1'b1;
                        2'b11:   r[i] = ~cur[i];
                        default: r[i] = cur[i];
                    endcase
                end
                return r;
            end
            2'd1:    return 4'((int'(cur) + 1) % 16);
            2'd2:    return 4'((int'(cur) + 15) % 16);
            default: return {cur[2:0], s};
        endcase
    endfunction

    function automatic logic model_tc(input logic [1:0] md, input logic [3:0] cur);
        return (md == 2'd1 && cur == 4'd15) || (md == 2'd2 && cur == 4'd0);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one edge's inputs at the falling edge. Queue what the outputs must show after
    // the next rising edge.
    task automatic step(input logic rn, input logic e, input logic [1:0] md,
                        input logic [3:0] jj, input logic [3:0] kk, input logic s);
        exp_t x;
        logic w0, w5;
        @(negedge clk);
        sync_reset_n = rn; en = e; mode = md; j = jj; k = kk; ser_in = s;
        w0 = rn && e && model_tc(md, m_q0);
        w5 = rn && e && model_tc(md, m_q5);
        m_q0 = model_next(m_q0, rn, e, md, jj, kk, s, 4'd0);
        m_q5 = model_next(m_q5, rn, e, md, jj, kk, s, 4'd5);
        if (!rn) m_known = 1'b1;
        x.q0 = m_q0; x.wrap0 = w0; x.tc0 = model_tc(md, m_q0);
        x.q5 = m_q5; x.wrap5 = w5; x.tc5 = model_tc(md, m_q5);
        if (m_known) sb_q.push_back(x);
    endtask

    // Load q0 to a value through JK mode (j=v, k=~v).
    task automatic load(input logic [3:0] v);
        step(1'b1, 1'b1, 2'd0, v, ~v, 1'b0);
    endtask

    // Monitor: compare every queued expectation just after the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("q",     q0,            x.q0);
                check("qnot",  qnot0,         ~x.q0);
                check("tc",    {3'b000, tc0},   {3'b000, x.tc0});
                check("wrap",  {3'b000, wrap0}, {3'b000, x.wrap0});
                check("q_rv5",    q5,            x.q5);
                check("qnot_rv5", qnot5,         ~x.q5);
                check("tc_rv5",   {3'b000, tc5},   {3'b000, x.tc5});
                check("wrap_rv5", {3'b000, wrap5}, {3'b000, x.wrap5});
            end
        end
    end

    initial begin
        m_q0 = 4'd0; m_q5 = 4'd0; m_known = 1'b0;
        sync_reset_n = 1'b1; en = 1'b0; mode = 2'd0; j = 4'd0; k = 4'd0; ser_in = 1'b0;

        // Reset for two edges with j=k=F in JK mode.
        step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);

        // JK truth table on bit 0, then a mixed vector from q=3.
        step(1'b1, 1'b1, 2'd0, 4'h1, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'h0, 4'h1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0);
        load(4'h3);
        step(1'b1, 1'b1, 2'd0, 4'hA, 4'h6, 1'b0);

        // Count up through the wrap, then hold at F with en low.
        load(4'hE);
        repeat (3) step(1'b1, 1'b1, 2'd1, 4'hF, 4'hF, 1'b1);
        load(4'hF);
        repeat (2) step(1'b1, 1'b0, 2'd1, 4'h0, 4'h0, 1'b0);

        // Count down through the wrap, then switch to up at F.
        load(4'h1);
        repeat (2) step(1'b1, 1'b1, 2'd2, 4'h5, 4'hA, 1'b1);
        step(1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 1'b0);

        // Shift 1,0,1,1,0 in from q=0.
        load(4'h0);
        step(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b1);
        step(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b1);
        step(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b1);
        step(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0);

        // Reset in the middle of counting, release, then reset with en low.
        load(4'h7);
        step(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Drain the queue and confirm every expectation was consumed.
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 4'(sb_q.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
